// File: rtl/apb_master.sv
// apb_master: APB requester behind a valid/ready command/response interface.
// Runs one transfer at a time through SETUP and ACCESS, honours PREADY wait
// states, and returns read data plus the slave error flag on a response
// channel that is held until consumed.
//
// Optional feature: define APB_MASTER_TIMEOUT_EN to abort an ACCESS phase
// after TIMEOUT_CYCLES consecutive PREADY-low cycles (rsp_err=1, rsp_rdata=0).
//
// Ports:
//   PCLK, PRESETn              clock, synchronous active-low reset
//   cmd_valid/cmd_ready        command handshake (cmd_ready = IDLE, combinational)
//   cmd_addr/write/wdata       command payload
//   rsp_valid/rsp_ready        response handshake, rsp_valid held until rsp_ready
//   rsp_rdata, rsp_err         read data (0 for writes/errors), error flag
//   PADDR..PWDATA              registered APB requester outputs
//   PRDATA, PREADY, PSLVERR    APB completer inputs
module apb_master #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic                  cmd_write,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [DATA_WIDTH-1:0] PWDATA,
   input  logic [DATA_WIDTH-1:0] PRDATA,
   input  logic                  PREADY,
   input  logic                  PSLVERR
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic [ADDR_WIDTH-1:0] paddr_nxt;
   logic                  psel_nxt;
   logic                  penable_nxt;
   logic                  pwrite_nxt;
   logic [DATA_WIDTH-1:0] pwdata_nxt;
   logic                  rsp_valid_nxt;
   logic [DATA_WIDTH-1:0] rsp_rdata_nxt;
   logic                  rsp_err_nxt;

   // Elaboration guard on the timeout length
   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("apb_master: TIMEOUT_CYCLES must be at least 1");
   end

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] wait_cnt;
   logic [CNT_W-1:0] wait_cnt_nxt;
   logic             timeout_c;

   // Last permitted low cycle: the TIMEOUT_CYCLES-th consecutive PREADY-low cycle
   assign timeout_c = (state == ACCESS) && !PREADY && (wait_cnt == CNT_LAST);
`endif

   assign cmd_ready = (state == IDLE);

   // State and registered outputs
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state     <= IDLE;
         PADDR     <= '0;
         PSEL      <= 1'b0;
         PENABLE   <= 1'b0;
         PWRITE    <= 1'b0;
         PWDATA    <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state     <= state_nxt;
         PADDR     <= paddr_nxt;
         PSEL      <= psel_nxt;
         PENABLE   <= penable_nxt;
         PWRITE    <= pwrite_nxt;
         PWDATA    <= pwdata_nxt;
         rsp_valid <= rsp_valid_nxt;
         rsp_rdata <= rsp_rdata_nxt;
         rsp_err   <= rsp_err_nxt;
      end
   end

`ifdef APB_MASTER_TIMEOUT_EN
   // Consecutive PREADY-low counter for the current ACCESS phase
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         wait_cnt <= '0;
      end else begin
         wait_cnt <= wait_cnt_nxt;
      end
   end
`endif

   // Next state and next register values; everything holds unless changed
   always_comb begin
      state_nxt     = state;
      paddr_nxt     = PADDR;
      psel_nxt      = PSEL;
      penable_nxt   = PENABLE;
      pwrite_nxt    = PWRITE;
      pwdata_nxt    = PWDATA;
      rsp_valid_nxt = rsp_valid;
      rsp_rdata_nxt = rsp_rdata;
      rsp_err_nxt   = rsp_err;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt_nxt  = wait_cnt;
`endif

      case (state)
         IDLE: begin
            if (cmd_valid) begin
               paddr_nxt   = cmd_addr;
               pwrite_nxt  = cmd_write;
               pwdata_nxt  = cmd_wdata;
               psel_nxt    = 1'b1;
               penable_nxt = 1'b0;
               state_nxt   = SETUP;
            end
         end

         SETUP: begin
            penable_nxt = 1'b1;
            state_nxt   = ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
            wait_cnt_nxt = '0;
`endif
         end

         ACCESS: begin
            if (PREADY) begin
               psel_nxt      = 1'b0;
               penable_nxt   = 1'b0;
               rsp_err_nxt   = PSLVERR;
               rsp_rdata_nxt = (!PWRITE && !PSLVERR) ? PRDATA : '0;
               rsp_valid_nxt = 1'b1;
               state_nxt     = RESP;
            end
`ifdef APB_MASTER_TIMEOUT_EN
            else if (timeout_c) begin
               psel_nxt      = 1'b0;
               penable_nxt   = 1'b0;
               rsp_err_nxt   = 1'b1;
               rsp_rdata_nxt = '0;
               rsp_valid_nxt = 1'b1;
               state_nxt     = RESP;
            end else begin
               wait_cnt_nxt = wait_cnt + CNT_W'(1);
            end
`endif
         end

         RESP: begin
            if (rsp_ready) begin
               rsp_valid_nxt = 1'b0;
               state_nxt     = IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule
